// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared definitions for the clock-gate enable controller.
//   ST_OFF/ST_WAKE/ST_ON/ST_DRAIN : 2-bit state encodings (also seen on GATE_STATE)
//   gate_state_e                  : FSM state type built from those encodings
//   clog2 / max_int               : elaboration-time helpers used to size the counter
package clk_gate_pkg;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_WAKE  = 2'b01;
  localparam logic [1:0] ST_ON    = 2'b11;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  typedef enum logic [1:0] {
    S_OFF   = ST_OFF,
    S_WAKE  = ST_WAKE,
    S_ON    = ST_ON,
    S_DRAIN = ST_DRAIN
  } gate_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if: status/request bundle between the system side and the
// clock-gate controller.
//   WAKE_REQ   : requester needs the gated clock running (level)
//   BUSY       : gated block has work in flight (level)
//   CLK_EN     : enable to the ICG
//   CLK_RDY    : gated clock is stable and usable
//   GATE_STATE : controller FSM state (debug/status)
// master = system/requester side, slave = the controller.
interface clk_gate_ctrl_if;
  logic       WAKE_REQ;
  logic       BUSY;
  logic       CLK_EN;
  logic       CLK_RDY;
  logic [1:0] GATE_STATE;

  modport master (
    output WAKE_REQ,
    output BUSY,
    input  CLK_EN,
    input  CLK_RDY,
    input  GATE_STATE
  );

  modport slave (
    input  WAKE_REQ,
    input  BUSY,
    output CLK_EN,
    output CLK_RDY,
    output GATE_STATE
  );
endinterface

// File: rtl/clk_gate_cnt.sv
// clk_gate_cnt: CNT_W-bit down-counter shared by the WAKE and DRAIN phases.
//   CLK     : clock
//   RST     : synchronous active-high reset (counter to 0)
//   i_load  : load i_ld_val (has priority over decrement)
//   i_ld_val: value to load
//   i_dec   : decrement enable; saturates at zero, never wraps
//   o_zero  : counter equals zero
module clk_gate_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_ld_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_ld_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: enable-side controller for an integrated clock gating cell.
// Opens the gate on WAKE_REQ, raises CLK_RDY WAKE_CYCLES after CLK_EN, and
// closes the gate after IDLE_CYCLES consecutive idle cycles in DRAIN.
//   CLK     : always-on clock
//   RST     : synchronous active-high reset
//   gif     : clk_gate_ctrl_if.slave (WAKE_REQ, BUSY in; CLK_EN, CLK_RDY,
//             GATE_STATE out)
//   TEST_EN : only when CLK_GATE_TEST_EN is defined; forces CLK_EN high
//             combinationally for scan/DFT without touching the FSM.
// Optional feature macro: CLK_GATE_TEST_EN.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          RST,
`ifdef CLK_GATE_TEST_EN
  input  logic          TEST_EN,
`endif
  clk_gate_ctrl_if.slave gif
);

  localparam int CNT_W = clog2(max_int(WAKE_CYCLES, IDLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

  gate_state_e      r_state;
  gate_state_e      w_state_next;
  logic             r_clk_en;
  logic             r_clk_rdy;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_dec;
  logic             w_zero;

  clk_gate_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .i_load   (w_load),
    .i_ld_val (w_ld_val),
    .i_dec    (w_dec),
    .o_zero   (w_zero)
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_ld_val     = '0;
    w_dec        = 1'b0;
    case (r_state)
      S_OFF: begin
        if (gif.WAKE_REQ) begin
          w_state_next = S_WAKE;
          w_load       = 1'b1;
          w_ld_val     = WAKE_LD;
        end
      end
      S_WAKE: begin
        // WAKE always runs to completion, even if the request goes away.
        if (w_zero) w_state_next = S_ON;
        else        w_dec        = 1'b1;
      end
      S_ON: begin
        if (!gif.WAKE_REQ && !gif.BUSY) begin
          w_state_next = S_DRAIN;
          w_load       = 1'b1;
          w_ld_val     = IDLE_LD;
        end
      end
      S_DRAIN: begin
        // Renewed activity wins over expiry; ON and DRAIN drive identical
        // outputs so the abort is glitch-free.
        if (gif.WAKE_REQ || gif.BUSY) w_state_next = S_ON;
        else if (w_zero)              w_state_next = S_OFF;
        else                          w_dec        = 1'b1;
      end
      default: w_state_next = S_OFF;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_OFF;
      r_clk_en  <= 1'b0;
      r_clk_rdy <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_en  <= (w_state_next != S_OFF);
      r_clk_rdy <= (w_state_next == S_ON) || (w_state_next == S_DRAIN);
    end
  end

`ifdef CLK_GATE_TEST_EN
  assign gif.CLK_EN = r_clk_en | TEST_EN;
`else
  assign gif.CLK_EN = r_clk_en;
`endif
  assign gif.CLK_RDY    = r_clk_rdy;
  assign gif.GATE_STATE = r_state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed bench for clk_gate_ctrl (WAKE_CYCLES=2,
// IDLE_CYCLES=4). Outputs are sampled 1 time unit after each rising edge,
// and new inputs are applied at the same point for the next edge.
module tb_clk_gate_ctrl;

  logic CLK;
  logic RST;
`ifdef CLK_GATE_TEST_EN
  logic TEST_EN;
`endif

  int vectors;
  int miscompares;
  int en_cycles;

  clk_gate_ctrl_if gif ();

  clk_gate_ctrl #(
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
`ifdef CLK_GATE_TEST_EN
    .TEST_EN (TEST_EN),
`endif
    .gif     (gif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic en, input logic rdy,
                     input logic [1:0] st);
    logic [3:0] obs;
    logic [3:0] exp_v;
    obs   = {gif.CLK_EN, gif.CLK_RDY, gif.GATE_STATE};
    exp_v = {en, rdy, st};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: got en=%b rdy=%b st=%b, want en=%b rdy=%b st=%b",
             tag, obs[3], obs[2], obs[1:0], en, rdy, st);
    end
    $display("vec %0d %s: en=%b rdy=%b st=%b", vectors, tag, obs[3], obs[2], obs[1:0]);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST          = 1'b1;
    gif.WAKE_REQ = 1'b1;
    gif.BUSY     = 1'b0;
`ifdef CLK_GATE_TEST_EN
    TEST_EN      = 1'b0;
`endif

    // Reset held with WAKE_REQ high: stays OFF.
    step(); chk("rst0", 1'b0, 1'b0, 2'b00);
    step(); chk("rst1", 1'b0, 1'b0, 2'b00);
    step(); chk("rst2", 1'b0, 1'b0, 2'b00);

    // Release: first sampled WAKE_REQ opens the gate on the next cycle.
    RST = 1'b0;
    step(); chk("post_rst_wake", 1'b1, 1'b0, 2'b01);
    step(); chk("post_rst_wake2", 1'b1, 1'b0, 2'b01);
    step(); chk("post_rst_on", 1'b1, 1'b1, 2'b11);

    // Idle close: 4 DRAIN cycles then OFF.
    gif.WAKE_REQ = 1'b0;
    step(); chk("drain_a1", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_a2", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_a3", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_a4", 1'b1, 1'b1, 2'b10);
    step(); chk("closed_a", 1'b0, 1'b0, 2'b00);

    // BUSY alone does not wake.
    gif.BUSY = 1'b1;
    step(); chk("busy_no_wake", 1'b0, 1'b0, 2'b00);
    gif.BUSY = 1'b0;

    // Wake latency from OFF.
    gif.WAKE_REQ = 1'b1;
    step(); chk("wake_c1", 1'b1, 1'b0, 2'b01);
    step(); chk("wake_c2", 1'b1, 1'b0, 2'b01);
    step(); chk("wake_c3_on", 1'b1, 1'b1, 2'b11);

    // BUSY alone keeps it ON.
    gif.WAKE_REQ = 1'b0;
    gif.BUSY     = 1'b1;
    step(); chk("busy_hold_on", 1'b1, 1'b1, 2'b11);

    // Drain abort at counter=1.
    gif.BUSY = 1'b0;
    step(); chk("drain_b1", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_b2", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_b3", 1'b1, 1'b1, 2'b10);
    gif.BUSY = 1'b1;
    step(); chk("abort_on", 1'b1, 1'b1, 2'b11);
    gif.BUSY = 1'b0;
    step(); chk("drain_c1", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_c2", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_c3", 1'b1, 1'b1, 2'b10);
    step(); chk("drain_c4_full", 1'b1, 1'b1, 2'b10);
    step(); chk("closed_c", 1'b0, 1'b0, 2'b00);

    // One-cycle WAKE_REQ pulse: enable held for 1+2+4 = 7 cycles.
    gif.WAKE_REQ = 1'b1;
    step(); chk("pulse_wake", 1'b1, 1'b0, 2'b01);
    gif.WAKE_REQ = 1'b0;
    en_cycles = 1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (gif.CLK_EN === 1'b1) en_cycles++;
    end
    vectors++;
    assert (en_cycles == 7) else begin
      miscompares++;
      $error("FAIL pulse_en_len: got %0d cycles, want 7", en_cycles);
    end
    $display("vec %0d pulse_en_len: %0d cycles", vectors, en_cycles);
    chk("pulse_closed", 1'b0, 1'b0, 2'b00);

    // Reset while ON drops both outputs on the next edge.
    gif.WAKE_REQ = 1'b1;
    step(); step(); step();
    chk("pre_rst_on", 1'b1, 1'b1, 2'b11);
    RST = 1'b1;
    step(); chk("rst_in_on", 1'b0, 1'b0, 2'b00);
    RST          = 1'b0;
    gif.WAKE_REQ = 1'b0;
    step(); chk("after_rst_off", 1'b0, 1'b0, 2'b00);

`ifdef CLK_GATE_TEST_EN
    // Test override: immediate, FSM untouched.
    TEST_EN = 1'b1;
    #1; chk("test_en_on", 1'b1, 1'b0, 2'b00);
    step(); chk("test_en_hold", 1'b1, 1'b0, 2'b00);
    TEST_EN = 1'b0;
    #1; chk("test_en_off", 1'b0, 1'b0, 2'b00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
